// File: rtl/demux_switch_n_pkg.sv
// Shared helpers for the 1-to-N demultiplexing switch.
package demux_switch_n_pkg;

  localparam int unsigned DEFAULT_CNT_W = 8;

  // Select width: clog2 of the channel count, never below one bit
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? unsigned'($clog2(n)) : 1;
  endfunction

  // Saturation value of a cnt_w-bit drop counter (valid for cnt_w <= 63)
  function automatic longint unsigned cnt_sat(input int unsigned cnt_w);
    return (64'd1 << cnt_w) - 64'd1;
  endfunction

endpackage

// File: rtl/demux_switch_n_slot.sv
// One-entry holding slot for a single output channel.
module switch_slot #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] data_in,
  input  logic         ready,
  output logic         full,
  output logic [W-1:0] data_out
);

  // Load has priority over drain so a slot can be emptied and refilled in one cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full     <= 1'b0;
      data_out <= '0;
    end else if (load) begin
      full     <= 1'b1;
      data_out <= data_in;
    end else if (ready) begin
      full     <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_switch_n.sv
// Registered 1-to-N demultiplexing switch with broadcast and out-of-range drop accounting.
module demux_switch_n
  import demux_switch_n_pkg::*;
#(
  parameter int unsigned N     = 2,
  parameter int unsigned W     = 1,
  parameter int unsigned SEL_W = sel_width(N),
  parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [SEL_W-1:0]   s,
  input  logic [W-1:0]       d,
  input  logic               bcast,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [N*W-1:0]     c,
  output logic [N-1:0]       c_valid,
  input  logic [N-1:0]       c_ready,
  output logic               drop,
  output logic [CNT_W-1:0]   drop_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_sat(CNT_W));

  logic [N-1:0] full;
  logic [N-1:0] free;
  logic [N-1:0] load;
  logic [W-1:0] slot_data [N];
  logic         s_in_range;
  logic         sel_free;
  logic         accept;
  logic         drop_now;

  // A slot is free when empty or being drained this cycle
  assign free = ~full | c_ready;

  // Decode the select against the real channel count (N need not be a power of two)
  always_comb begin
    s_in_range = 1'b0;
    sel_free   = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (s == SEL_W'(i)) begin
        s_in_range = 1'b1;
        sel_free   = free[i];
      end
    end
  end

  // Broadcast needs every slot free; out-of-range beats are always taken and discarded
  assign in_ready = rst_n & (bcast ? (&free) : (s_in_range ? sel_free : 1'b1));
  assign accept   = in_valid & in_ready;
  assign drop_now = accept & ~bcast & ~s_in_range;

  // Per-channel load strobes
  always_comb begin
    load = '0;
    for (int unsigned i = 0; i < N; i++) begin
      load[i] = accept & (bcast | (s == SEL_W'(i)));
    end
  end

  // Slot array and zero-gated channel outputs
  for (genvar g = 0; g < N; g++) begin : g_slot
    switch_slot #(
      .W (W)
    ) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load[g]),
      .data_in  (d),
      .ready    (c_ready[g]),
      .full     (full[g]),
      .data_out (slot_data[g])
    );

    assign c[g*W +: W] = full[g] ? slot_data[g] : '0;
  end

  assign c_valid = full;

  // Drop pulse and saturating drop counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop       <= 1'b0;
      drop_count <= '0;
    end else begin
      drop <= drop_now;
      if (drop_now && (drop_count != CNT_MAX)) begin
        drop_count <= drop_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_demux_switch_n.sv
// Self-checking bench for demux_switch_n (N=3, W=8, CNT_W=2).
module tb_demux_switch_n;

  localparam int unsigned N     = 3;
  localparam int unsigned W     = 8;
  localparam int unsigned SEL_W = 2;
  localparam int unsigned CNT_W = 2;
  localparam int          SAT   = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic [SEL_W-1:0] s;
  logic [W-1:0]     d;
  logic             bcast;
  logic             in_valid;
  logic             in_ready;
  logic [N*W-1:0]   c;
  logic [N-1:0]     c_valid;
  logic [N-1:0]     c_ready;
  logic             drop;
  logic [CNT_W-1:0] drop_count;

  int vectors;
  int miscompares;

  // Reference model: what each channel currently holds, plus drop bookkeeping
  bit           m_has [N];
  logic [W-1:0] m_val [N];
  int           m_cnt;
  bit           m_drop;

  // Producer-rule tracking
  bit           pend;
  logic [SEL_W-1:0] ps;
  logic [W-1:0] pd;
  bit           pb;

  demux_switch_n #(
    .N     (N),
    .W     (W),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s          (s),
    .d          (d),
    .bcast      (bcast),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .c          (c),
    .c_valid    (c_valid),
    .c_ready    (c_ready),
    .drop       (drop),
    .drop_count (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit m_ready();
    if (!rst_n) return 1'b0;
    if (bcast) begin
      for (int i = 0; i < N; i++) if (m_has[i] && !c_ready[i]) return 1'b0;
      return 1'b1;
    end
    if (int'(s) < N) return !m_has[int'(s)] || c_ready[int'(s)];
    return 1'b1;
  endfunction

  function automatic logic [N*W-1:0] m_c();
    logic [N*W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) if (m_has[i]) r[i*W +: W] = m_val[i];
    return r;
  endfunction

  function automatic logic [N-1:0] m_valid();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = m_has[i];
    return r;
  endfunction

  // Advance one clock: producer-rule check, model update at the edge, return at negedge
  task automatic step();
    bit acc;
    if (pend) begin
      vectors++;
      if (s !== ps || d !== pd || bcast !== pb) begin
        miscompares++;
        $display("FAIL producer_rule: s/d/bcast got %h/%h/%b required %h/%h/%b", s, d, bcast, ps, pd, pb);
      end
    end
    acc  = in_valid && m_ready();
    pend = rst_n && in_valid && !acc;
    ps = s; pd = d; pb = bcast;
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin m_has[i] = 0; m_val[i] = '0; end
      m_cnt  = 0;
      m_drop = 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (c_ready[i]) m_has[i] = 0;
        if (acc && (bcast || int'(s) == i)) begin m_has[i] = 1; m_val[i] = d; end
      end
      m_drop = acc && !bcast && int'(s) >= N;
      if (m_drop && m_cnt < SAT) m_cnt++;
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 0; in_valid = 0; bcast = 0; s = '0; d = '0; c_ready = '0;
    step();
    step();
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0; in_valid = 1; s = '0; d = 8'h5A; bcast = 0; c_ready = '0;
    repeat (3) step();
    #1;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready: got %b required 0", in_ready); end
    vectors++; if (c_valid !== 3'b000) begin miscompares++; $display("FAIL reset_c_valid: got %b required 000", c_valid); end
    vectors++; if (c !== 24'h000000) begin miscompares++; $display("FAIL reset_c: got %h required 000000", c); end
    vectors++; if (drop_count !== 2'd0) begin miscompares++; $display("FAIL reset_drop_count: got %0d required 0", drop_count); end
    vectors++; if (drop !== 1'b0) begin miscompares++; $display("FAIL reset_drop: got %b required 0", drop); end
    rst_n = 1;
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL release_in_ready: got %b required 1", in_ready); end
    in_valid = 0;
    step();
  endtask

  task automatic test_reset_mid();
    c_ready = '0; s = 2'd2; d = 8'h99; bcast = 0; in_valid = 1;
    step();
    in_valid = 0;
    #1;
    vectors++; if (c_valid !== 3'b100) begin miscompares++; $display("FAIL mid_loaded: got %b required 100", c_valid); end
    rst_n = 0;
    step();
    #1;
    vectors++; if (c_valid !== 3'b000 || c !== 24'h000000) begin miscompares++; $display("FAIL mid_reset: got %b/%h required 000/000000", c_valid, c); end
    rst_n = 1;
    step();
  endtask

  task automatic test_basic_steer();
    c_ready = 3'b111; s = 2'd1; d = 8'hA5; bcast = 0; in_valid = 1;
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL steer_in_ready: got %b required 1", in_ready); end
    step();
    in_valid = 0;
    #1;
    vectors++; if (c_valid !== 3'b010) begin miscompares++; $display("FAIL steer_c_valid: got %b required 010", c_valid); end
    vectors++; if (c !== 24'h00A500) begin miscompares++; $display("FAIL steer_c: got %h required 00a500", c); end
    step();
    #1;
    vectors++; if (c_valid !== 3'b000 || c !== 24'h000000) begin miscompares++; $display("FAIL steer_empty: got %b/%h required 000/000000", c_valid, c); end
  endtask

  task automatic test_backpressure();
    c_ready = 3'b000; s = 2'd0; d = 8'h11; bcast = 0; in_valid = 1;
    step();
    d = 8'h22;
    #1;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_stall: got %b required 0", in_ready); end
    vectors++; if (c_valid !== 3'b001 || c[7:0] !== 8'h11) begin miscompares++; $display("FAIL bp_first: got %b/%h required 001/11", c_valid, c[7:0]); end
    step();
    #1;
    vectors++; if (in_ready !== 1'b0 || c[7:0] !== 8'h11) begin miscompares++; $display("FAIL bp_hold: got %b/%h required 0/11", in_ready, c[7:0]); end
    c_ready = 3'b001;
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release: got %b required 1", in_ready); end
    step();
    in_valid = 0; c_ready = 3'b000;
    #1;
    vectors++; if (c_valid !== 3'b001 || c[7:0] !== 8'h22) begin miscompares++; $display("FAIL bp_second: got %b/%h required 001/22", c_valid, c[7:0]); end
    c_ready = 3'b001;
    step();
    #1;
    vectors++; if (c_valid !== 3'b000) begin miscompares++; $display("FAIL bp_drain: got %b required 000", c_valid); end
  endtask

  task automatic test_broadcast();
    c_ready = 3'b011; s = 2'd2; d = 8'h77; bcast = 0; in_valid = 1;
    step();
    bcast = 1; s = 2'd0; d = 8'h3C;
    #1;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bc_blocked: got %b required 0", in_ready); end
    step();
    #1;
    vectors++; if (c_valid !== 3'b100 || c !== 24'h770000) begin miscompares++; $display("FAIL bc_no_partial: got %b/%h required 100/770000", c_valid, c); end
    c_ready = 3'b111;
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bc_ready: got %b required 1", in_ready); end
    step();
    in_valid = 0; bcast = 0; c_ready = 3'b000;
    #1;
    vectors++; if (c_valid !== 3'b111 || c !== 24'h3C3C3C) begin miscompares++; $display("FAIL bc_all: got %b/%h required 111/3c3c3c", c_valid, c); end
    c_ready = 3'b111;
    step();
  endtask

  task automatic test_out_of_range();
    apply_reset();
    c_ready = 3'b111; s = 2'd3; d = 8'hE7; bcast = 0; in_valid = 1;
    for (int k = 1; k <= 5; k++) begin
      int e;
      e = (k < SAT) ? k : SAT;
      #1;
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL oor_in_ready[%0d]: got %b required 1", k, in_ready); end
      step();
      #1;
      vectors++; if (drop !== 1'b1 || c_valid !== 3'b000) begin miscompares++; $display("FAIL oor_drop[%0d]: got %b/%b required 1/000", k, drop, c_valid); end
      vectors++; if (drop_count !== CNT_W'(e)) begin miscompares++; $display("FAIL oor_count[%0d]: got %0d required %0d", k, drop_count, e); end
    end
    in_valid = 0;
    step();
    #1;
    vectors++; if (drop !== 1'b0 || drop_count !== CNT_W'(SAT)) begin miscompares++; $display("FAIL oor_end: got %b/%0d required 0/%0d", drop, drop_count, SAT); end
  endtask

  task automatic test_streaming();
    c_ready = 3'b111; bcast = 0;
    for (int k = 0; k < 16; k++) begin
      int ch;
      ch = k % 2;
      s = SEL_W'(ch); d = W'(k); in_valid = 1;
      #1;
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL stream_ready[%0d]: got %b required 1", k, in_ready); end
      step();
      #1;
      vectors++;
      if (c_valid !== N'(1 << ch) || c[ch*W +: W] !== W'(k)) begin
        miscompares++;
        $display("FAIL stream_beat[%0d]: got %b/%h required %b/%h", k, c_valid, c[ch*W +: W], N'(1 << ch), W'(k));
      end
    end
    in_valid = 0;
    step();
  endtask

  task automatic test_random();
    apply_reset();
    for (int k = 0; k < 600; k++) begin
      if (!pend) begin
        in_valid = ($urandom_range(0, 3) != 0);
        s        = SEL_W'($urandom_range(0, 3));
        d        = W'($urandom);
        bcast    = ($urandom_range(0, 7) == 0);
      end
      c_ready = N'($urandom);
      #1;
      vectors++; if (in_ready !== m_ready()) begin miscompares++; $display("FAIL rnd_in_ready[%0d]: got %b required %b", k, in_ready, m_ready()); end
      vectors++; if (c_valid !== m_valid()) begin miscompares++; $display("FAIL rnd_c_valid[%0d]: got %b required %b", k, c_valid, m_valid()); end
      vectors++; if (c !== m_c()) begin miscompares++; $display("FAIL rnd_c[%0d]: got %h required %h", k, c, m_c()); end
      vectors++; if (drop !== m_drop) begin miscompares++; $display("FAIL rnd_drop[%0d]: got %b required %b", k, drop, m_drop); end
      vectors++; if (drop_count !== CNT_W'(m_cnt)) begin miscompares++; $display("FAIL rnd_drop_count[%0d]: got %0d required %0d", k, drop_count, m_cnt); end
      step();
    end
    in_valid = 0;
    step();
  endtask

  initial begin
    vectors = 0; miscompares = 0; pend = 0;
    m_cnt = 0; m_drop = 0;
    for (int i = 0; i < N; i++) begin m_has[i] = 0; m_val[i] = '0; end
    rst_n = 0; in_valid = 0; bcast = 0; s = '0; d = '0; c_ready = '0;
    test_reset();
    test_reset_mid();
    test_basic_steer();
    test_backpressure();
    test_broadcast();
    test_out_of_range();
    test_streaming();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
